// File: rtl/multicycle_rca.sv
// -----------------------------------------------------------------------------
// multicycle_rca
//
// Multi-cycle ripple-carry adder. The WIDTH-bit add is split into
// N = WIDTH/CHUNK slices. One CHUNK-bit ripple-carry slice is processed per
// clock, and the carry is held in a register between slices. sum, cout and
// ovf change only on the completion edge, so they never show a partial
// result.
//
// Parameters
//   WIDTH  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK  bits added per clock; N = WIDTH/CHUNK clocks per add
//
// Ports
//   clk    clock; all logic runs on the rising edge
//   rst    synchronous, active-high reset
//   start  add request; sampled only while busy=0
//   a, b   operands, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   sub    (MULTICYCLE_RCA_SUB_EN only) 1 = compute a + ~b + 1; cin ignored
//   busy   high while an add is in progress
//   done   one-cycle pulse; sum/cout/ovf hold the new result
//   sum    result, modulo 2^WIDTH
//   cout   unsigned carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//   ovf    two's-complement overflow (carry into MSB ^ carry out of MSB)
//
// Build option
//   MULTICYCLE_RCA_SUB_EN  when defined, adds the 'sub' input port.
// -----------------------------------------------------------------------------
module multicycle_rca #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef MULTICYCLE_RCA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Reject illegal slicing at elaboration time.
    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
            $error("multicycle_rca: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    localparam int N     = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One CHUNK-bit ripple slice.
    // Returns {carry into top bit, carry out of top bit, slice sum}.
    // The carry into the top bit is kept because, in the last slice, it is
    // the carry into bit WIDTH-1 that the overflow flag needs.
    function automatic logic [CHUNK+1:0] ripple_slice(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        logic             c;
        logic             c_top_in;
        logic [CHUNK-1:0] s;
        c        = ci;
        c_top_in = ci;
        s        = {CHUNK{1'b0}};
        for (int i = 0; i < CHUNK; i++) begin
            c_top_in = c;
            s[i]     = x[i] ^ y[i] ^ c;
            c        = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c_top_in, c, s};
    endfunction

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   wsum_r;

    logic [31:0]        base_s;
    logic [CHUNK-1:0]   slice_a_s;
    logic [CHUNK-1:0]   slice_b_s;
    logic [CHUNK+1:0]   slice_res_s;
    logic [CHUNK-1:0]   slice_sum_s;
    logic               slice_cout_s;
    logic               slice_ctop_s;
    logic [WIDTH-1:0]   next_wsum_s;
    logic [WIDTH-1:0]   capture_b_s;
    logic               capture_c_s;

    // Operand conditioning at capture: subtraction is a + ~b + 1.
    always_comb begin
`ifdef MULTICYCLE_RCA_SUB_EN
        capture_b_s = sub ? ~b : b;
        capture_c_s = sub ? 1'b1 : cin;
`else
        capture_b_s = b;
        capture_c_s = cin;
`endif
    end

    // Current slice add and the working sum with this slice merged in.
    always_comb begin
        base_s       = 32'(idx_r) * 32'(CHUNK);
        slice_a_s    = CHUNK'(a_r >> base_s);
        slice_b_s    = CHUNK'(b_r >> base_s);
        slice_res_s  = ripple_slice(slice_a_s, slice_b_s, carry_r);
        slice_sum_s  = slice_res_s[CHUNK-1:0];
        slice_cout_s = slice_res_s[CHUNK];
        slice_ctop_s = slice_res_s[CHUNK+1];
        next_wsum_s  = (wsum_r & ~(SLICE_MASK << base_s))
                     | (WIDTH'(slice_sum_s) << base_s);
    end

    // Control FSM, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= 1'b0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            wsum_r  <= {WIDTH{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= {WIDTH{1'b0}};
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= capture_b_s;
                        carry_r <= capture_c_s;
                        wsum_r  <= {WIDTH{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    wsum_r  <= next_wsum_s;
                    carry_r <= slice_cout_s;
                    if (idx_r == LAST_IDX) begin
                        // Completion edge: publish the full result at once.
                        sum     <= next_wsum_s;
                        cout    <= slice_cout_s;
                        ovf     <= slice_ctop_s ^ slice_cout_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        idx_r   <= {IDX_W{1'b0}};
                        state_r <= IDLE;
                    end else begin
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        idx_r   <= idx_r + IDX_ONE;
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= {IDX_W{1'b0}};
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_rca.sv
// -----------------------------------------------------------------------------
// tb_multicycle_rca
//
// Two instances share clock, reset and operands: dut0 (WIDTH=16, CHUNK=4,
// four slices) and dut1 (WIDTH=16, CHUNK=16, one slice); each has its own
// start. A behavioural model computes every result with plain full-width
// arithmetic and counts down the latency; a negedge process compares all
// outputs of both instances against it every cycle. Directed adds also check
// hand-computed literal results and latency.
// -----------------------------------------------------------------------------
module tb_multicycle_rca;

    logic        clk;
    logic        rst;
    logic [1:0]  st;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;

    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [1:0]  cout_v;
    logic [1:0]  ovf_v;
    logic [15:0] sum_v [2];

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    multicycle_rca #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .a(a), .b(b), .cin(cin),
`ifdef MULTICYCLE_RCA_SUB_EN
        .sub(sub),
`endif
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
        .cout(cout_v[0]), .ovf(ovf_v[0])
    );

    multicycle_rca #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .a(a), .b(b), .cin(cin),
`ifdef MULTICYCLE_RCA_SUB_EN
        .sub(sub),
`endif
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
        .cout(cout_v[1]), .ovf(ovf_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference result: {ovf, cout, sum} from plain 17-bit arithmetic.
    function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic s);
        logic [15:0] yy;
        logic        cc;
        logic [16:0] r;
        yy = s ? ~y : y;
        cc = s ? 1'b1 : c;
        r  = {1'b0, x} + {1'b0, yy} + {16'd0, cc};
        return {(x[15] == yy[15]) && (r[15] != x[15]), r[16], r[15:0]};
    endfunction

    // ---------------- behavioural model ----------------
    logic        m_busy [2];
    logic        m_done [2];
    logic [15:0] m_sum  [2];
    logic        m_cout [2];
    logic        m_ovf  [2];
    logic [17:0] m_pend [2];
    int          m_cnt  [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] <= 1'b0;
                m_done[k] <= 1'b0;
                m_sum[k]  <= 16'h0000;
                m_cout[k] <= 1'b0;
                m_ovf[k]  <= 1'b0;
                m_cnt[k]  <= 0;
            end else if (!m_busy[k]) begin
                m_done[k] <= 1'b0;
                if (st[k]) begin
                    m_busy[k] <= 1'b1;
                    m_cnt[k]  <= (k == 0) ? 4 : 1;
                    m_pend[k] <= ref_add(a, b, cin, sub);
                end
            end else begin
                m_cnt[k] <= m_cnt[k] - 1;
                if (m_cnt[k] == 1) begin
                    m_busy[k] <= 1'b0;
                    m_done[k] <= 1'b1;
                    m_sum[k]  <= m_pend[k][15:0];
                    m_cout[k] <= m_pend[k][16];
                    m_ovf[k]  <= m_pend[k][17];
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("d%0d_busy", k), busy_v[k], m_busy[k]);
                check($sformatf("d%0d_done", k), done_v[k], m_done[k]);
                check($sformatf("d%0d_sum",  k), sum_v[k],  m_sum[k]);
                check($sformatf("d%0d_cout", k), cout_v[k], m_cout[k]);
                check($sformatf("d%0d_ovf",  k), ovf_v[k],  m_ovf[k]);
            end
        end
    end

    // One directed add on instance k with literal expectations and latency.
    task automatic run_add(input int k, input logic [15:0] ta, input logic [15:0] tb,
                           input logic tc, input logic ts, input logic [15:0] es,
                           input logic ec, input logic eo, input string nm);
        int cyc;
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc;    // operands change after capture
        cyc = 0;
        while (done_v[k] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s_done", nm), done_v[k], 32'd1);
        check($sformatf("%s_lat",  nm), cyc, (k == 0) ? 32'd4 : 32'd1);
        check($sformatf("%s_sum",  nm), sum_v[k], es);
        check($sformatf("%s_cout", nm), cout_v[k], ec);
        check($sformatf("%s_ovf",  nm), ovf_v[k], eo);
        sub = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int dcount;
        rst = 1'b1; st = 2'b00; a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst%0d_busy", k), busy_v[k], 32'd0);
            check($sformatf("rst%0d_done", k), done_v[k], 32'd0);
            check($sformatf("rst%0d_sum",  k), sum_v[k],  32'd0);
            check($sformatf("rst%0d_cout", k), cout_v[k], 32'd0);
            check($sformatf("rst%0d_ovf",  k), ovf_v[k],  32'd0);
        end
        rst = 1'b0;

        // Directed adds on the four-slice instance
        run_add(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_5555");
        run_add(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        run_add(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
        run_add(0, 16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, "ripple_cin");
        run_add(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "all_ones");
        run_add(0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");

        // Single-slice instance
        run_add(1, 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, "n1_add");
        run_add(1, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "n1_cin");

`ifdef MULTICYCLE_RCA_SUB_EN
        run_add(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        run_add(0, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        run_add(1, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "n1_sub");
`endif

        // start held high with new operands every cycle: one result per 5 cycles
        @(negedge clk);
        st[0] = 1'b1;
        last = -1;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            a = 16'h1357 + 16'(i * 16'h0421);
            b = 16'hF00D ^ 16'(i * 16'h0113);
            cin = i[0];
            @(negedge clk);
            if (done_v[0] === 1'b1) begin
                if (last >= 0) check("b2b_period", i - last, 32'd5);
                last = i;
                dcount++;
            end
        end
        st[0] = 1'b0;
        check("b2b_count", dcount, 32'd6);

        // Leave a non-zero result behind, then reset in the middle of a run
        run_add(0, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, "pre_rst");
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F0F; cin = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy_v[0], 32'd0);
        check("abort_done", done_v[0], 32'd0);
        check("abort_sum",  sum_v[0],  32'd0);
        check("abort_cout", cout_v[0], 32'd0);
        check("abort_ovf",  ovf_v[0],  32'd0);
        repeat (6) begin
            @(negedge clk);
            check("abort_nodone", done_v[0], 32'd0);
        end
        run_add(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, "after_rst");

        // rst and start at the same edge: reset wins
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; st[0] = 1'b1; rst = 1'b1;
        @(negedge clk);
        st[0] = 1'b0; rst = 1'b0;
        check("rst_wins_busy", busy_v[0], 32'd0);
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
